// File: rtl/trig_acq_sequencer.sv
// Trigger/record sequencer on the ADC sample clock: pre-fill, trigger, post capture, holdoff, accumulation.
// Optional macro TRIG_TIMESTAMP_EN builds a 32-bit free-running timestamp latched on each accepted trigger.
module trig_acq_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 14,
  parameter int HOLD_W  = 16,
  parameter int ACC_W   = 8,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic               force_trig_i,
  input  logic [NUM_SRC-1:0] trig_in_i,
  input  logic [SEL_W-1:0]   src_sel_i,
  input  logic [CNT_W-1:0]   pre_count_i,
  input  logic [CNT_W-1:0]   post_count_i,
  input  logic [HOLD_W-1:0]  holdoff_i,
  input  logic [ACC_W-1:0]   num_acc_i,
  input  logic               auto_rearm_i,
  input  logic               store_ready_i,
  output logic               write_en_o,
  output logic               first_sample_o,
  output logic               last_sample_o,
  output logic               record_done_o,
  output logic               acc_done_o,
  output logic [ACC_W-1:0]   record_index_o,
  output logic               overrun_o,
  output logic [31:0]        trig_time_o,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    PRE   = 4'd1,
    ARMED = 4'd2,
    POST  = 4'd3,
    HOLD  = 4'd4,
    DONE  = 4'd5
  } state_t;

  state_t              state_q;
  logic [NUM_SRC-1:0]  prev_q;
  logic [SEL_W-1:0]    srcSel_q;
  logic [CNT_W-1:0]    pre_q;
  logic [CNT_W-1:0]    postEff_q;
  logic [HOLD_W-1:0]   holdoff_q;
  logic [ACC_W-1:0]    numAcc_q;
  logic                autoRearm_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [ACC_W-1:0]    recIdx_q;
  logic                recordDone_q;
  logic                accDone_q;
  logic                overrun_q;

  logic                srcValid;
  logic                trigEdge;
  logic                storeOk;
  logic [CNT_W-1:0]    cntInc;
  logic [HOLD_W-1:0]   holdInc;
  logic [ACC_W-1:0]    recInc;
  logic                recEnd;
  state_t              restartState;
  state_t              afterRecState;

  // Strobes are combinational so the edge-cycle sample is written with zero latency.
  always_comb begin
    srcValid      = ({1'b0, srcSel_q} < (SEL_W + 1)'(NUM_SRC));
    trigEdge      = (srcValid & trig_in_i[srcSel_q] & ~prev_q[srcSel_q]) | force_trig_i;
    storeOk       = store_ready_i & ~disarm_i;
    cntInc        = cnt_q + CNT_W'(1);
    holdInc       = hold_q + HOLD_W'(1);
    recInc        = recIdx_q + ACC_W'(1);
    restartState  = (pre_q == '0) ? ARMED : PRE;
    write_en_o    = storeOk & ((state_q == PRE) | (state_q == ARMED) | (state_q == POST));
    first_sample_o = storeOk & (((state_q == ARMED) & trigEdge) |
                                ((state_q == POST) & (cnt_q == '0)));
    last_sample_o  = storeOk & (((state_q == ARMED) & trigEdge & (postEff_q == CNT_W'(1))) |
                                ((state_q == POST) & (cntInc == postEff_q)));
    recEnd        = last_sample_o;
    if (recInc == numAcc_q) begin
      afterRecState = DONE;
    end else if (holdoff_q == '0) begin
      afterRecState = restartState;
    end else begin
      afterRecState = HOLD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      prev_q       <= '1;
      srcSel_q     <= '0;
      pre_q        <= '0;
      postEff_q    <= CNT_W'(1);
      holdoff_q    <= '0;
      numAcc_q     <= ACC_W'(1);
      autoRearm_q  <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= '0;
      recIdx_q     <= '0;
      recordDone_q <= 1'b0;
      accDone_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      prev_q       <= trig_in_i;
      recordDone_q <= 1'b0;
      accDone_q    <= 1'b0;
      if (disarm_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm_i) begin
              srcSel_q    <= src_sel_i;
              pre_q       <= pre_count_i;
              postEff_q   <= (post_count_i == '0) ? CNT_W'(1) : post_count_i;
              holdoff_q   <= holdoff_i;
              numAcc_q    <= (num_acc_i == '0) ? ACC_W'(1) : num_acc_i;
              autoRearm_q <= auto_rearm_i;
              recIdx_q    <= '0;
              overrun_q   <= 1'b0;
              cnt_q       <= '0;
              state_q     <= (pre_count_i == '0) ? ARMED : PRE;
            end
          end
          PRE: begin
            if (store_ready_i) begin
              if (cntInc == pre_q) begin
                cnt_q   <= '0;
                state_q <= ARMED;
              end else begin
                cnt_q <= cntInc;
              end
            end
          end
          ARMED: begin
            if (trigEdge) begin
              state_q <= POST;
              if (store_ready_i) begin
                cnt_q <= CNT_W'(1);
              end else begin
                cnt_q     <= '0;
                overrun_q <= 1'b1;
              end
            end
          end
          POST: begin
            if (store_ready_i) begin
              cnt_q <= cntInc;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          HOLD: begin
            if (holdInc == holdoff_q) begin
              cnt_q   <= '0;
              state_q <= restartState;
            end else begin
              hold_q <= holdInc;
            end
          end
          DONE: begin
            if (autoRearm_q) begin
              recIdx_q <= '0;
              hold_q   <= '0;
              cnt_q    <= '0;
              state_q  <= (holdoff_q == '0) ? restartState : HOLD;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
        // The record's final write overrides the per-state counter update above.
        if (recEnd) begin
          recordDone_q <= 1'b1;
          recIdx_q     <= recInc;
          cnt_q        <= '0;
          hold_q       <= '0;
          accDone_q    <= (afterRecState == DONE);
          state_q      <= afterRecState;
        end
      end
    end
  end

  assign record_done_o  = recordDone_q;
  assign acc_done_o     = accDone_q;
  assign record_index_o = recIdx_q;
  assign overrun_o      = overrun_q;
  assign state_o        = state_q;

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] tsCnt_q;
  logic [31:0] trigTime_q;
  logic        trigAccept;

  assign trigAccept = ~disarm_i & (state_q == ARMED) & trigEdge;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tsCnt_q    <= '0;
      trigTime_q <= '0;
    end else begin
      tsCnt_q <= tsCnt_q + 32'd1;
      if (trigAccept) begin
        trigTime_q <= tsCnt_q;
      end
    end
  end

  assign trig_time_o = trigTime_q;
`else
  assign trig_time_o = '0;
`endif

endmodule
